// File: rtl/ddr3_app_pkg.sv
// ddr3_app_pkg: shared command codes, responder states and beat addressing constant
package ddr3_app_pkg;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ = 3'b001;
  localparam int BEAT_ADDR_SHIFT = 3;
  typedef enum logic [2:0] {S_CALIB, S_IDLE, S_WR, S_RD, S_RD_DRAIN} state_e;
endpackage

// File: rtl/ddr3_resp_mem.sv
// ddr3_resp_mem: beat array with per-byte write enables and a registered read port
module ddr3_resp_mem #(
  parameter int AW = 8,
  parameter int DW = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW/8-1:0]   we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DW-1:0]     rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  always_ff @(posedge clk)
    for (int b = 0; b < DW/8; b++)
      if (we_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
endmodule

// File: rtl/ddr3_app_responder.sv
// ddr3_app_responder: DDR3 app-side stand-in storing bursts and replaying reads at fixed latency
module ddr3_app_responder
  import ddr3_app_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128,
  parameter int MEM_DEPTH_LOG2 = 8,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              app_burst_number,
  input  logic [2:0]              cmd,
  input  logic                    cmd_en,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_data_en,
  input  logic                    wr_data_end,
  input  logic [DATA_WIDTH/8-1:0] wr_data_mask,
  output logic                    wr_data_rdy,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_data_valid,
  output logic                    rd_data_end,
  output logic                    init_calib_complete,
  output logic                    proto_err
);
  localparam int AW = MEM_DEPTH_LOG2;
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int L = RD_LATENCY;
  state_e state_q;
  logic [CW-1:0] cal_q;
  logic [5:0] burst_q, beat_q;
  logic [AW-1:0] idx_q;
  logic [L-1:0] vld_q, end_q;
  logic [AW-1:0] pidx_q [L-1];
  logic calib_q, err_q, accept, wr_beat, last, issue, unused_addr;
  assign accept = cmd_en && state_q == S_IDLE;
  assign wr_beat = wr_data_en && state_q == S_WR;
  assign last = beat_q == burst_q;
  assign issue = state_q == S_RD;
  assign cmd_ready = state_q == S_IDLE;
  assign wr_data_rdy = state_q == S_WR;
  assign rd_data_valid = vld_q[L-1];
  assign rd_data_end = end_q[L-1];
  assign init_calib_complete = calib_q;
  assign proto_err = err_q;
  assign unused_addr = ^{addr[ADDR_WIDTH-1:BEAT_ADDR_SHIFT+AW], addr[BEAT_ADDR_SHIFT-1:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_CALIB;
      cal_q <= '0;
      burst_q <= '0;
      beat_q <= '0;
      idx_q <= '0;
      vld_q <= '0;
      end_q <= '0;
      calib_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      vld_q <= {vld_q[L-2:0], issue};
      end_q <= {end_q[L-2:0], issue && last};
      if ((cmd_en && state_q != S_IDLE) || (wr_data_en && state_q != S_WR) ||
          (accept && cmd != CMD_WRITE && cmd != CMD_READ) || (wr_beat && wr_data_end != last))
        err_q <= 1'b1;
      case (state_q)
        S_CALIB: begin
          cal_q <= cal_q + 1'b1;
          if (cal_q == CW'(CALIB_CYCLES - 1)) begin
            state_q <= S_IDLE;
            calib_q <= 1'b1;
          end
        end
        S_IDLE: if (accept) begin
          burst_q <= app_burst_number;
          beat_q <= '0;
          idx_q <= addr[BEAT_ADDR_SHIFT +: AW];
          state_q <= cmd == CMD_WRITE ? S_WR : cmd == CMD_READ ? S_RD : S_IDLE;
        end
        S_WR: if (wr_data_en) begin
          beat_q <= beat_q + 1'b1;
          idx_q <= idx_q + 1'b1;
          if (last) state_q <= S_IDLE;
        end
        S_RD: begin
          beat_q <= beat_q + 1'b1;
          idx_q <= idx_q + 1'b1;
          if (last) state_q <= S_RD_DRAIN;
        end
        S_RD_DRAIN: if (vld_q[L-2:0] == '0) state_q <= S_IDLE;
        default: state_q <= S_CALIB;
      endcase
    end
  // index pipeline feeds the array read one stage before the valid reaches the output
  always_ff @(posedge clk) begin
    pidx_q[0] <= idx_q;
    for (int i = 1; i < L - 1; i++) pidx_q[i] <= pidx_q[i-1];
  end
  ddr3_resp_mem #(.AW(AW), .DW(DATA_WIDTH)) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   ({(DATA_WIDTH/8){wr_beat}} & ~wr_data_mask),
    .waddr_i(idx_q),
    .wdata_i(wr_data),
    .re_i   (vld_q[L-2]),
    .raddr_i(pidx_q[L-2]),
    .rdata_o(rd_data)
  );
endmodule

// File: tb/tb_ddr3_app_responder.sv
// tb_ddr3_app_responder: randomized self-checking bench against a behavioural beat-array model
module tb_ddr3_app_responder;
  localparam int LAT = 4;
  localparam int CAL = 64;
  logic clk = 0, rst_n = 0;
  logic [5:0] app_burst_number = '0;
  logic [2:0] cmd = '0;
  logic cmd_en = 0, cmd_ready;
  logic [26:0] addr = '0;
  logic [127:0] wr_data = '0;
  logic wr_data_en = 0, wr_data_end = 0;
  logic [15:0] wr_data_mask = '0;
  logic wr_data_rdy;
  logic [127:0] rd_data;
  logic rd_data_valid, rd_data_end, init_calib_complete, proto_err;
  logic [127:0] model [256];
  logic [127:0] wbuf [64];
  logic [15:0] mbuf [64];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  ddr3_app_responder #(
    .ADDR_WIDTH(27), .DATA_WIDTH(128), .MEM_DEPTH_LOG2(8), .CALIB_CYCLES(CAL), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .app_burst_number(app_burst_number), .cmd(cmd), .cmd_en(cmd_en),
    .cmd_ready(cmd_ready), .addr(addr), .wr_data(wr_data), .wr_data_en(wr_data_en),
    .wr_data_end(wr_data_end), .wr_data_mask(wr_data_mask), .wr_data_rdy(wr_data_rdy),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_end(rd_data_end),
    .init_calib_complete(init_calib_complete), .proto_err(proto_err)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] ix(input logic [26:0] a, input int i);
    return a[10:3] + 8'(i);
  endfunction
  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_wr_rdy"}, wr_data_rdy, 0);
    check({tag, "_rd_valid"}, rd_data_valid, 0);
    check({tag, "_rd_end"}, rd_data_end, 0);
    check({tag, "_calib"}, init_calib_complete, 0);
    check({tag, "_proto_err"}, proto_err, 0);
    check({tag, "_rd_data"}, rd_data, 0);
  endtask
  task automatic wait_calib(input string tag);
    int k = 0;
    int rdy_k = -1;
    while (!init_calib_complete && k < 200) begin
      tick;
      k++;
      if (cmd_ready && rdy_k < 0) rdy_k = k;
    end
    check({tag, "_calib_cycle"}, k, CAL);
    check({tag, "_cmd_ready_cycle"}, rdy_k, CAL);
  endtask
  task automatic write_burst(input logic [26:0] a, input int n, input int bad);
    check("wr_cmd_ready", cmd_ready, 1);
    cmd_en = 1; cmd = 3'b000; addr = a; app_burst_number = 6'(n - 1);
    tick;
    cmd_en = 0;
    check("wr_cmd_drop", cmd_ready, 0);
    for (int i = 0; i < n; i++) begin
      check("wr_rdy", wr_data_rdy, 1);
      wr_data_en = 1; wr_data = wbuf[i]; wr_data_mask = mbuf[i];
      wr_data_end = (i == n - 1) || (i == bad);
      for (int b = 0; b < 16; b++)
        if (!mbuf[i][b]) model[ix(a, i)][b*8 +: 8] = wbuf[i][b*8 +: 8];
      tick;
    end
    wr_data_en = 0; wr_data_end = 0;
    check("wr_done_cmd_ready", cmd_ready, 1);
    check("wr_done_rdy_low", wr_data_rdy, 0);
  endtask
  task automatic read_burst(input logic [26:0] a, input int n);
    int k = 0;
    logic [127:0] lastv = '0;
    check("rd_cmd_ready", cmd_ready, 1);
    cmd_en = 1; cmd = 3'b001; addr = a; app_burst_number = 6'(n - 1);
    tick;
    cmd_en = 0;
    for (int t = 1; t <= n + LAT + 4; t++) begin
      tick;
      if (t == LAT + n - 1) check("rd_busy", cmd_ready, 0);
      if (t == LAT + n) check("rd_done_cmd_ready", cmd_ready, 1);
      if (rd_data_valid) begin
        lastv = model[ix(a, k)];
        check("rd_time", t, LAT + k);
        check("rd_data", rd_data, lastv);
        check("rd_end", rd_data_end, 1'(k == n - 1));
        k++;
      end
    end
    check("rd_beats", k, n);
    check("rd_hold", rd_data, lastv);
  endtask
  initial begin
    logic [127:0] single_v;
    repeat (3) tick;
    check_reset_outputs("por");
    rst_n = 1;
    wait_calib("por");
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 64; i++) begin
        wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
        mbuf[i] = '0;
      end
      write_burst(27'(j * 512), 64, -1);
    end
    single_v = 128'h0123456789ABCDEF0123456789ABCDEF;
    wbuf[0] = single_v; mbuf[0] = '0;
    write_burst(27'h40, 1, -1);
    read_burst(27'h40, 1);
    check("single_value", rd_data, single_v);
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 128'(i + 1);
      mbuf[i] = '0;
    end
    write_burst(27'h0, 4, -1);
    read_burst(27'h0, 4);
    check("burst4_last", rd_data, 128'd4);
    wbuf[0] = '1; mbuf[0] = '0;
    write_burst(27'h100, 1, -1);
    wbuf[0] = '0; mbuf[0] = 16'h00FF;
    write_burst(27'h100, 1, -1);
    read_burst(27'h100, 1);
    check("mask_value", rd_data, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    wbuf[0] = {$urandom, $urandom, $urandom, $urandom};
    wbuf[1] = {$urandom, $urandom, $urandom, $urandom};
    mbuf[0] = '0; mbuf[1] = '0;
    write_burst(27'(255 << 3), 2, -1);
    read_burst(27'h0, 1);
    check("wrap_value", rd_data, wbuf[1]);
    for (int r = 0; r < 25; r++) begin
      logic [26:0] a;
      int n;
      a = 27'($urandom);
      n = $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) begin
          wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
          mbuf[i] = 16'($urandom);
        end
        write_burst(a, n, -1);
      end else read_burst(a, n);
    end
    check("no_err_clean", proto_err, 0);
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
      mbuf[i] = '0;
    end
    write_burst(27'h200, 4, 0);
    check("early_end_err", proto_err, 1);
    read_burst(27'h200, 4);
    rst_n = 0;
    tick;
    check_reset_outputs("rst2");
    rst_n = 1;
    wait_calib("rst2");
    cmd_en = 1; cmd = 3'b111; addr = '0; app_burst_number = '0;
    tick;
    cmd_en = 0;
    check("illegal_err", proto_err, 1);
    check("illegal_cmd_ready", cmd_ready, 1);
    check("illegal_wr_rdy", wr_data_rdy, 0);
    tick;
    check("illegal_stay_idle", cmd_ready, 1);
    cmd_en = 1; cmd = 3'b001; addr = 27'h0; app_burst_number = 6'd7;
    tick;
    cmd_en = 0;
    repeat (LAT) tick;
    check("midrd_valid_before", rd_data_valid, 1);
    #1 rst_n = 0;
    #1;
    check("midrd_valid_cleared", rd_data_valid, 0);
    check("midrd_data_cleared", rd_data, 0);
    check("midrd_cmd_ready", cmd_ready, 0);
    check("midrd_err_cleared", proto_err, 0);
    #1 rst_n = 1;
    wait_calib("midrd");
    read_burst(27'h40, 1);
    read_burst(27'h0, 8);
    check("final_no_err", proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr3_app_responder.md
# ddr3_app_responder

- Simulation and bring-up stand-in for the DDR3 memory-interface IP, seen from its user side.
- Acts as the responder on the app command/data interface that the DDR test engine drives:
  - accepts write and read bursts;
  - stores data in a small internal array;
  - returns read data with a fixed latency.
- Lets the tester and UART reporting path be checked without the PHY, PLL or DDR3 device.

## Interface
Parameters:
- ADDR_WIDTH, 27: app address width, in 16-bit word units.
- DATA_WIDTH, 128: beat width (x16 device, BL8).
- MEM_DEPTH_LOG2, 8: log2 of the number of 128-bit beats stored.
- CALIB_CYCLES, 64: cycles after reset before calibration reports complete.
- RD_LATENCY, 4: cycles from read-command acceptance to the first rd_data_valid; minimum 2.

Ports:
- clk, input, 1: single clock. Every port is synchronous to it.
- rst_n, input, 1: asynchronous, active-low reset.
- app_burst_number, input, 6: beats per command minus 1.
- cmd, input, 3: command code. 3'b000 = write, 3'b001 = read, other codes are illegal.
- cmd_en, input, 1: command valid.
- cmd_ready, output, 1: responder can accept a command.
- addr, input, ADDR_WIDTH: start address of the burst.
- wr_data, input, DATA_WIDTH: write beat.
- wr_data_en, input, 1: write beat valid.
- wr_data_end, input, 1: marks the last beat of a write burst.
- wr_data_mask, input, DATA_WIDTH/8: bit i = 1 blocks the write of byte i.
- wr_data_rdy, output, 1: responder can accept a write beat.
- rd_data, output, DATA_WIDTH: read beat.
- rd_data_valid, output, 1: read beat valid.
- rd_data_end, output, 1: marks the last read beat of a burst.
- init_calib_complete, output, 1: calibration is done.
- proto_err, output, 1: sticky protocol-violation flag.

## Operation
- States are CALIB, IDLE, WR, RD and RD_DRAIN.
- CALIB:
  - entered on reset;
  - counts CALIB_CYCLES, then goes to IDLE and sets init_calib_complete, which stays 1 until the next reset.
- IDLE:
  - cmd_ready = 1.
  - A command is accepted on a cycle with cmd_en & cmd_ready.
  - On acceptance, addr, cmd and app_burst_number are latched, and beats = app_burst_number + 1 (1 to 64).
  - A write command goes to WR, a read command goes to RD.
  - An illegal cmd sets proto_err and the state stays IDLE.
- Addressing:
  - array index = addr[3 +: MEM_DEPTH_LOG2], incremented by 1 per beat;
  - the index wraps modulo 2^MEM_DEPTH_LOG2;
  - upper address bits are ignored (aliasing).
- WR:
  - wr_data_rdy = 1, and one beat is accepted per cycle with wr_data_en.
  - Unmasked bytes are written to the array.
  - After `beats` beats, the state goes to IDLE.
  - wr_data_end asserted on any beat other than the last, or missing on the last beat, sets proto_err. The beat is still written.
- RD:
  - issues one array read per cycle, `beats` times in total, into a RD_LATENCY-deep valid/end/index pipeline;
  - then goes to RD_DRAIN.
- RD_DRAIN:
  - waits until the pipeline is empty, then goes to IDLE.
- Errors outside IDLE:
  - cmd_en while cmd_ready = 0 sets proto_err and is ignored.
  - wr_data_en outside WR sets proto_err and is ignored.
- Reset:
  - An rst_n assertion during any burst aborts it immediately and returns to CALIB.
  - Array contents are not reset; they are undefined after power-up and retained across reset.

## Timing
Reset values:
- cmd_ready, wr_data_rdy, rd_data_valid, rd_data_end, init_calib_complete and proto_err are all 0.
- rd_data is 0.

Latencies:
- init_calib_complete and cmd_ready rise at cycle CALIB_CYCLES after rst_n deasserts.
- cmd_ready drops in the cycle after acceptance.
- Write: wr_data_rdy is high from acceptance+1 until the last beat's cycle inclusive. cmd_ready is 1 in the cycle after the last beat.
- Read:
  - the first rd_data_valid comes RD_LATENCY cycles after the acceptance edge;
  - beats follow back to back with no gaps;
  - rd_data_end is on beat `beats`;
  - cmd_ready = 1 in the cycle after the last valid beat.

Hazards:
- A read of an index written in an earlier burst returns the new data. Commands are serialized, so there is no same-cycle hazard.
- rd_data holds its last value when rd_data_valid = 0.

## Structure
- Shared package ddr3_app_pkg holds:
  - command codes CMD_WRITE and CMD_READ;
  - the state enum;
  - the BEAT_ADDR_SHIFT = 3 constant.
- Sub-module ddr3_resp_mem: a simple dual-port array with per-byte write enables and a 1-cycle registered read. The remaining latency is made up by the valid pipeline.

## Test plan
- Reset and calibration: release rst_n -> init_calib_complete and cmd_ready both rise exactly at cycle 64; all outputs are 0 before that.
- Single-beat round trip: write burst 0 at addr 0x40, data 0x0123...CDEF, mask 0 -> read addr 0x40 returns the same data, with rd_data_valid and rd_data_end together at acceptance+4.
- Burst of 4: write burst_number 3 at addr 0, data 1..4 -> read back 4 consecutive beats 1..4, with rd_data_end only on the 4th beat.
- Byte mask: write all-FF, then write all-00 with mask 16'h00FF -> readback 0x00...00FF...FF, i.e. the upper 8 bytes are 00 and the lower 8 bytes are FF.
- Wrap: write 2 beats at index 255 (addr 255<<3) -> the second beat lands at index 0 and reads back from addr 0.
- Errors and reset:
  - wr_data_end on beat 1 of a 4-beat write -> proto_err = 1;
  - cmd 3'b111 -> proto_err = 1 and cmd_ready stays 1;
  - rst_n pulsed mid-read -> rd_data_valid = 0 immediately and the calibration count restarts.
